// File: rtl/sfu_lane_sequencer_if.sv
// Request, SFU-core and writeback signals of the lane sequencer, grouped as one bundle.
// slave = sequencer side; master = dispatcher/SFU-core/writeback side.
interface sfu_lane_sequencer_if #(
  parameter int LANES = 4,
  parameter int DW    = 24
) ();
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [LANES*DW-1:0]   req_operand_i;
  logic [2:0]            req_op_i;
  logic [LANES-1:0]      req_mask_i;
  logic [5:0]            req_dest_i;

  logic [DW-1:0]         sfu_core_operand_o;
  logic [2:0]            sfu_core_special_op_o;
  logic                  sfu_valid_o;
  logic [DW-1:0]         sfu_core_result_i;
  logic                  sfu_core_valid_i;

  logic                  wb_valid_o;
  logic [LANES*DW-1:0]   wb_result_o;
  logic [LANES-1:0]      wb_mask_o;
  logic [5:0]            wb_dest_o;
  logic                  wb_err_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_operand_i, req_op_i, req_mask_i, req_dest_i,
    input  sfu_core_result_i, sfu_core_valid_i,
    output req_ready_o, sfu_core_operand_o, sfu_core_special_op_o, sfu_valid_o,
    output wb_valid_o, wb_result_o, wb_mask_o, wb_dest_o, wb_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_operand_i, req_op_i, req_mask_i, req_dest_i,
    output sfu_core_result_i, sfu_core_valid_i,
    input  req_ready_o, sfu_core_operand_o, sfu_core_special_op_o, sfu_valid_o,
    input  wb_valid_o, wb_result_o, wb_mask_o, wb_dest_o, wb_err_o, busy_o
  );
endinterface

// File: rtl/sfu_lane_sequencer.sv
// Serialises a masked LANES-wide SFU request onto a single-lane core, one issue per active lane, then one vector writeback.
// Issue 1 cycle after accept or after each response; wb 1 cycle after the last response; no new request until wb is done.
module sfu_lane_sequencer #(
  parameter int LANES   = 4,
  parameter int DW      = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sfu_lane_sequencer_if.slave  bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic                        r_ready;
  logic [LANES-1:0]            r_pending, w_pending_nxt;
  logic [LW-1:0]               r_lane, w_lane_nxt;
  logic [TW-1:0]               r_timer, w_timer_nxt;
  logic [LANES-1:0][DW-1:0]    r_ops, w_ops_nxt;
  logic [2:0]                  r_op, w_op_nxt;
  logic [LANES-1:0]            r_mask, w_mask_nxt;
  logic [5:0]                  r_dest, w_dest_nxt;
  logic [LANES-1:0][DW-1:0]    r_res, w_res_nxt;
  logic                        r_err, w_err_nxt;

  logic                        r_sfu_vld, w_sfu_vld_nxt;
  logic [DW-1:0]               r_sfu_opnd, w_sfu_opnd_nxt;
  logic [2:0]                  r_sfu_op, w_sfu_op_nxt;
  logic                        r_wb_vld, w_wb_vld_nxt;
  logic [LANES-1:0][DW-1:0]    r_wb_res, w_wb_res_nxt;
  logic [LANES-1:0]            r_wb_mask, w_wb_mask_nxt;
  logic [5:0]                  r_wb_dest, w_wb_dest_nxt;
  logic                        r_wb_err, w_wb_err_nxt;

  logic [LANES-1:0][DW-1:0]    w_ops_in;
  logic                        w_timeout;
  logic                        w_advance;
  logic                        w_go_issue;
  logic                        w_go_done;

  function automatic logic [LW-1:0] f_lowest(input logic [LANES-1:0] p);
    logic [LW-1:0] l;
    l = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (p[i]) l = LW'(i);
    end
    return l;
  endfunction

  assign w_ops_in  = bus.req_operand_i;
  assign w_timeout = (TIMEOUT != 0) && (r_timer == T_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_lane_nxt     = r_lane;
    w_timer_nxt    = r_timer;
    w_ops_nxt      = r_ops;
    w_op_nxt       = r_op;
    w_mask_nxt     = r_mask;
    w_dest_nxt     = r_dest;
    w_res_nxt      = r_res;
    w_err_nxt      = r_err;
    w_sfu_vld_nxt  = 1'b0;
    w_sfu_opnd_nxt = r_sfu_opnd;
    w_sfu_op_nxt   = r_sfu_op;
    w_wb_vld_nxt   = 1'b0;
    w_wb_res_nxt   = r_wb_res;
    w_wb_mask_nxt  = r_wb_mask;
    w_wb_dest_nxt  = r_wb_dest;
    w_wb_err_nxt   = r_wb_err;
    w_advance      = 1'b0;
    w_go_issue     = 1'b0;
    w_go_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_ops_nxt     = w_ops_in;
          w_op_nxt      = bus.req_op_i;
          w_mask_nxt    = bus.req_mask_i;
          w_dest_nxt    = bus.req_dest_i;
          w_pending_nxt = bus.req_mask_i;
          w_res_nxt     = '0;
          w_err_nxt     = 1'b0;
          w_go_issue    = |bus.req_mask_i;
          w_go_done     = ~|bus.req_mask_i;
        end
      end
      S_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving on the watchdog's last cycle still counts as good data.
        if (bus.sfu_core_valid_i) begin
          w_res_nxt[r_lane]     = bus.sfu_core_result_i;
          w_pending_nxt[r_lane] = 1'b0;
          w_advance             = 1'b1;
        end else if (w_timeout) begin
          w_res_nxt[r_lane]     = '0;
          w_pending_nxt[r_lane] = 1'b0;
          w_err_nxt             = 1'b1;
          w_advance             = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_advance) begin
      w_go_issue = |w_pending_nxt;
      w_go_done  = ~|w_pending_nxt;
    end

    // Issue/writeback registers load on the transition edge so the pulse lines up with ISSUE/DONE.
    if (w_go_issue) begin
      w_state_nxt    = S_ISSUE;
      w_lane_nxt     = f_lowest(w_pending_nxt);
      w_sfu_vld_nxt  = 1'b1;
      w_sfu_opnd_nxt = w_ops_nxt[w_lane_nxt];
      w_sfu_op_nxt   = w_op_nxt;
    end

    if (w_go_done) begin
      w_state_nxt   = S_DONE;
      w_wb_vld_nxt  = 1'b1;
      w_wb_res_nxt  = w_res_nxt;
      w_wb_mask_nxt = w_mask_nxt;
      w_wb_dest_nxt = w_dest_nxt;
      w_wb_err_nxt  = w_err_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_pending  <= '0;
      r_lane     <= '0;
      r_timer    <= '0;
      r_ops      <= '0;
      r_op       <= '0;
      r_mask     <= '0;
      r_dest     <= '0;
      r_res      <= '0;
      r_err      <= 1'b0;
      r_sfu_vld  <= 1'b0;
      r_sfu_opnd <= '0;
      r_sfu_op   <= '0;
      r_wb_vld   <= 1'b0;
      r_wb_res   <= '0;
      r_wb_mask  <= '0;
      r_wb_dest  <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_pending  <= w_pending_nxt;
      r_lane     <= w_lane_nxt;
      r_timer    <= w_timer_nxt;
      r_ops      <= w_ops_nxt;
      r_op       <= w_op_nxt;
      r_mask     <= w_mask_nxt;
      r_dest     <= w_dest_nxt;
      r_res      <= w_res_nxt;
      r_err      <= w_err_nxt;
      r_sfu_vld  <= w_sfu_vld_nxt;
      r_sfu_opnd <= w_sfu_opnd_nxt;
      r_sfu_op   <= w_sfu_op_nxt;
      r_wb_vld   <= w_wb_vld_nxt;
      r_wb_res   <= w_wb_res_nxt;
      r_wb_mask  <= w_wb_mask_nxt;
      r_wb_dest  <= w_wb_dest_nxt;
      r_wb_err   <= w_wb_err_nxt;
    end
  end

  assign bus.req_ready_o           = r_ready;
  assign bus.busy_o                = ~r_ready;
  assign bus.sfu_valid_o           = r_sfu_vld;
  assign bus.sfu_core_operand_o    = r_sfu_opnd;
  assign bus.sfu_core_special_op_o = r_sfu_op;
  assign bus.wb_valid_o            = r_wb_vld;
  assign bus.wb_result_o           = r_wb_res;
  assign bus.wb_mask_o             = r_wb_mask;
  assign bus.wb_dest_o             = r_wb_dest;
  assign bus.wb_err_o              = r_wb_err;

endmodule

// File: tb/tb_sfu_lane_sequencer.sv
// Directed bench for sfu_lane_sequencer: a 2-cycle SFU core model answers each issue; cycle 0 is the accept cycle.
module tb_sfu_lane_sequencer;
  localparam int LANES   = 4;
  localparam int DW      = 24;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sfu_lane_sequencer_if #(.LANES(LANES), .DW(DW)) bus ();

  sfu_lane_sequencer #(.LANES(LANES), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks;
  int failures;
  int cyc;

  bit          pend_vld;
  int          pend_due;
  logic [23:0] pend_res;
  bit          drop_en;
  logic [23:0] drop_opnd;
  bit          inject_en;
  bit          inject_armed;
  int          inject_done;
  logic [23:0] iss_opnd[$];
  int          iss_cyc[$];
  logic [2:0]  exp_op;
  int          op_bad;
  int          overlap;
  int          wb_cnt;
  int          wb_cycq[$];
  logic [95:0] wb_res;
  logic [3:0]  wb_m;
  logic [5:0]  wb_d;
  logic        wb_e;
  logic        rdy_at_wb;

  task automatic model_clear();
    pend_vld     = 1'b0;
    drop_en      = 1'b0;
    inject_en    = 1'b0;
    inject_armed = 1'b0;
    inject_done  = 0;
    iss_opnd.delete();
    iss_cyc.delete();
    op_bad       = 0;
    overlap      = 0;
    wb_cnt       = 0;
    wb_cycq.delete();
  endtask

  // One clock of the SFU core model plus monitoring, executed at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    bus.sfu_core_valid_i  = 1'b0;
    bus.sfu_core_result_i = '0;
    if (pend_vld && cyc == pend_due) begin
      bus.sfu_core_valid_i  = 1'b1;
      bus.sfu_core_result_i = pend_res;
      pend_vld = 1'b0;
    end
    if (bus.sfu_valid_o === 1'b1) begin
      if (pend_vld) overlap++;
      iss_opnd.push_back(bus.sfu_core_operand_o);
      iss_cyc.push_back(cyc);
      if (bus.sfu_core_special_op_o !== exp_op) op_bad++;
      if (inject_armed) begin
        bus.sfu_core_valid_i  = 1'b1;
        bus.sfu_core_result_i = 24'hABCDEF;
        inject_armed = 1'b0;
        inject_done++;
      end
      if (drop_en && bus.sfu_core_operand_o == drop_opnd) begin
        inject_armed = inject_en;
      end else begin
        pend_vld = 1'b1;
        pend_due = cyc + 2;
        pend_res = bus.sfu_core_operand_o + 24'd1;
      end
    end
    if (bus.wb_valid_o === 1'b1) begin
      wb_cnt++;
      wb_cycq.push_back(cyc);
      wb_res    = bus.wb_result_o;
      wb_m      = bus.wb_mask_o;
      wb_d      = bus.wb_dest_o;
      wb_e      = bus.wb_err_o;
      rdy_at_wb = bus.req_ready_o;
    end
  endtask

  task automatic start_req(input logic [3:0] m, input logic [95:0] ops, input logic [2:0] op, input logic [5:0] d);
    bus.req_mask_i    = m;
    bus.req_operand_i = ops;
    bus.req_op_i      = op;
    bus.req_dest_i    = d;
    exp_op            = op;
    bus.req_valid_i   = 1'b1;
    cyc = 0;
    step();
    bus.req_valid_i   = 1'b0;
  endtask

  task automatic wait_wb(input int n, input int budget);
    for (int i = 0; i < budget && wb_cnt < n; i++) step();
  endtask

  function automatic logic [95:0] iss_ops_packed();
    logic [95:0] v;
    v = '0;
    for (int i = 0; i < iss_opnd.size() && i < 4; i++) v[i*24 +: 24] = iss_opnd[i];
    return v;
  endfunction

  function automatic logic [31:0] iss_cyc_packed();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < iss_cyc.size() && i < 4; i++) v[i*8 +: 8] = 8'(iss_cyc[i]);
    return v;
  endfunction

  function automatic int wb_cyc_at(input int idx);
    if (idx < wb_cycq.size()) return wb_cycq[idx];
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if ({bus.sfu_valid_o, bus.wb_valid_o, bus.wb_err_o} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses: got %b want 000", {bus.sfu_valid_o, bus.wb_valid_o, bus.wb_err_o}); end
    checks++; if ({bus.sfu_core_operand_o, bus.sfu_core_special_op_o, bus.wb_result_o, bus.wb_mask_o, bus.wb_dest_o} !== '0) begin failures++;
      $display("FAIL reset_data: got %h want 0", {bus.sfu_core_operand_o, bus.sfu_core_special_op_o, bus.wb_result_o, bus.wb_mask_o, bus.wb_dest_o}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin failures++;
      $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0", bus.req_ready_o, bus.busy_o); end
  endtask

  task automatic test_full_mask();
    model_clear();
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_before: got %b want 1", bus.req_ready_o); end
    start_req(4'hF, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b010, 6'h25);
    wait_wb(1, 60);
    checks++; if (wb_cyc_at(0) != 13) begin failures++; $display("FAIL full_wb_cycle: got %0d want 13", wb_cyc_at(0)); end
    checks++; if (iss_opnd.size() != 4) begin failures++; $display("FAIL full_issue_count: got %0d want 4", iss_opnd.size()); end
    checks++; if (iss_cyc_packed() !== 32'h0A070401) begin failures++; $display("FAIL full_issue_cycles: got %h want 0a070401", iss_cyc_packed()); end
    checks++; if (iss_ops_packed() !== {24'd4, 24'd3, 24'd2, 24'd1}) begin failures++; $display("FAIL full_issue_operands: got %h", iss_ops_packed()); end
    checks++; if (op_bad != 0 || overlap != 0) begin failures++; $display("FAIL full_op_overlap: got op_bad=%0d overlap=%0d want 0/0", op_bad, overlap); end
    checks++; if (wb_res !== {24'd5, 24'd4, 24'd3, 24'd2}) begin failures++; $display("FAIL full_wb_result: got %h want 000005000004000003000002", wb_res); end
    checks++; if ({wb_m, wb_d, wb_e} !== {4'hF, 6'h25, 1'b0}) begin failures++; $display("FAIL full_wb_fields: got mask=%h dest=%h err=%b", wb_m, wb_d, wb_e); end
    checks++; if (rdy_at_wb !== 1'b0) begin failures++; $display("FAIL full_ready_at_wb: got %b want 0", rdy_at_wb); end
    step();
    checks++; if (bus.req_ready_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin failures++;
      $display("FAIL full_after_wb: got ready=%b wb_valid=%b want 1/0", bus.req_ready_o, bus.wb_valid_o); end
    checks++; if (bus.wb_result_o !== {24'd5, 24'd4, 24'd3, 24'd2}) begin failures++; $display("FAIL full_wb_hold: got %h", bus.wb_result_o); end
  endtask

  task automatic test_sparse_mask();
    model_clear();
    start_req(4'b1010, {24'd40, 24'd30, 24'd20, 24'd10}, 3'b001, 6'h0A);
    wait_wb(1, 60);
    checks++; if (iss_opnd.size() != 2) begin failures++; $display("FAIL sparse_issue_count: got %0d want 2", iss_opnd.size()); end
    checks++; if (iss_ops_packed() !== {24'd0, 24'd0, 24'd40, 24'd20}) begin failures++; $display("FAIL sparse_issue_operands: got %h", iss_ops_packed()); end
    checks++; if (iss_cyc_packed() !== 32'h00000401) begin failures++; $display("FAIL sparse_issue_cycles: got %h want 00000401", iss_cyc_packed()); end
    checks++; if (wb_cyc_at(0) != 7) begin failures++; $display("FAIL sparse_wb_cycle: got %0d want 7", wb_cyc_at(0)); end
    checks++; if (wb_res !== {24'd41, 24'd0, 24'd21, 24'd0}) begin failures++; $display("FAIL sparse_wb_result: got %h want 000029000000000015000000", wb_res); end
    checks++; if ({wb_m, wb_d, wb_e} !== {4'b1010, 6'h0A, 1'b0}) begin failures++; $display("FAIL sparse_wb_fields: got mask=%b dest=%h err=%b", wb_m, wb_d, wb_e); end
    step();
  endtask

  task automatic test_timeout();
    model_clear();
    drop_en   = 1'b1;
    drop_opnd = 24'd3;
    inject_en = 1'b1;
    start_req(4'hF, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b100, 6'h3F);
    wait_wb(1, 80);
    checks++; if (iss_opnd.size() != 4) begin failures++; $display("FAIL to_issue_count: got %0d want 4", iss_opnd.size()); end
    checks++; if (iss_cyc_packed() !== 32'h10070401) begin failures++; $display("FAIL to_issue_cycles: got %h want 10070401", iss_cyc_packed()); end
    checks++; if (inject_done != 1) begin failures++; $display("FAIL to_late_injected: got %0d want 1", inject_done); end
    checks++; if (wb_cyc_at(0) != 19) begin failures++; $display("FAIL to_wb_cycle: got %0d want 19", wb_cyc_at(0)); end
    checks++; if (wb_res !== {24'd5, 24'd0, 24'd3, 24'd2}) begin failures++; $display("FAIL to_wb_result: got %h want 000005000000000003000002", wb_res); end
    checks++; if ({wb_m, wb_e} !== {4'hF, 1'b1}) begin failures++; $display("FAIL to_wb_err: got mask=%h err=%b want f/1", wb_m, wb_e); end
    step();
  endtask

  task automatic test_empty_mask();
    model_clear();
    start_req(4'b0000, {4{24'hFFFFFF}}, 3'b011, 6'h11);
    wait_wb(1, 20);
    checks++; if (wb_cyc_at(0) != 1) begin failures++; $display("FAIL empty_wb_cycle: got %0d want 1", wb_cyc_at(0)); end
    checks++; if (iss_opnd.size() != 0) begin failures++; $display("FAIL empty_issue_count: got %0d want 0", iss_opnd.size()); end
    checks++; if ({wb_res, wb_m, wb_d, wb_e} !== {96'd0, 4'd0, 6'h11, 1'b0}) begin failures++;
      $display("FAIL empty_wb_fields: got res=%h mask=%b dest=%h err=%b", wb_res, wb_m, wb_d, wb_e); end
    checks++; if (rdy_at_wb !== 1'b0) begin failures++; $display("FAIL empty_ready_at_wb: got %b want 0", rdy_at_wb); end
    step();
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL empty_ready_after: got %b want 1", bus.req_ready_o); end
  endtask

  task automatic test_reset_mid();
    model_clear();
    start_req(4'hF, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b010, 6'h05);
    for (int i = 0; i < 20 && iss_opnd.size() < 2; i++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin failures++;
      $display("FAIL rstmid_idle: got ready=%b busy=%b want 1/0", bus.req_ready_o, bus.busy_o); end
    checks++; if ({bus.sfu_valid_o, bus.wb_valid_o, bus.wb_err_o} !== 3'b000) begin failures++;
      $display("FAIL rstmid_pulses: got %b want 000", {bus.sfu_valid_o, bus.wb_valid_o, bus.wb_err_o}); end
    checks++; if ({bus.sfu_core_operand_o, bus.sfu_core_special_op_o, bus.wb_result_o, bus.wb_mask_o, bus.wb_dest_o} !== '0) begin failures++;
      $display("FAIL rstmid_data: got %h want 0", {bus.sfu_core_operand_o, bus.sfu_core_special_op_o, bus.wb_result_o, bus.wb_mask_o, bus.wb_dest_o}); end
    repeat (3) step();
    checks++; if (bus.req_ready_o !== 1'b1 || iss_opnd.size() != 2 || wb_cnt != 0) begin failures++;
      $display("FAIL rstmid_stale_ignored: got ready=%b issues=%0d wb=%0d want 1/2/0", bus.req_ready_o, iss_opnd.size(), wb_cnt); end
    model_clear();
    start_req(4'b0001, {72'd0, 24'd7}, 3'b101, 6'h2A);
    wait_wb(1, 40);
    checks++; if (wb_cyc_at(0) != 4) begin failures++; $display("FAIL rstmid_new_wb_cycle: got %0d want 4", wb_cyc_at(0)); end
    checks++; if ({wb_res, wb_m, wb_d, wb_e} !== {72'd0, 24'd8, 4'b0001, 6'h2A, 1'b0}) begin failures++;
      $display("FAIL rstmid_new_wb: got res=%h mask=%b dest=%h err=%b", wb_res, wb_m, wb_d, wb_e); end
    step();
  endtask

  task automatic test_back_to_back();
    int accept_b;
    model_clear();
    bus.req_mask_i    = 4'b0011;
    bus.req_operand_i = {24'd0, 24'd0, 24'h22, 24'h11};
    bus.req_op_i      = 3'b110;
    bus.req_dest_i    = 6'h01;
    exp_op            = 3'b110;
    bus.req_valid_i   = 1'b1;
    cyc = 0;
    step();
    bus.req_mask_i    = 4'b0100;
    bus.req_operand_i = {24'd0, 24'h33, 24'd0, 24'd0};
    bus.req_dest_i    = 6'h02;
    accept_b = -1;
    for (int i = 0; i < 80 && wb_cnt < 2; i++) begin
      if (accept_b < 0 && bus.req_ready_o === 1'b1) begin
        accept_b = cyc;
        step();
        bus.req_valid_i = 1'b0;
      end else begin
        step();
      end
    end
    bus.req_valid_i = 1'b0;
    checks++; if (accept_b != 8) begin failures++; $display("FAIL b2b_accept_cycle: got %0d want 8", accept_b); end
    checks++; if (wb_cyc_at(0) != 7 || wb_cyc_at(1) != 12) begin failures++;
      $display("FAIL b2b_wb_cycles: got %0d,%0d want 7,12", wb_cyc_at(0), wb_cyc_at(1)); end
    checks++; if (iss_cyc_packed() !== 32'h00090401 || overlap != 0) begin failures++;
      $display("FAIL b2b_issues: got cycles=%h overlap=%0d want 00090401/0", iss_cyc_packed(), overlap); end
    checks++; if (iss_ops_packed() !== {24'd0, 24'h33, 24'h22, 24'h11}) begin failures++; $display("FAIL b2b_operands: got %h", iss_ops_packed()); end
    checks++; if ({wb_res, wb_m, wb_d, wb_e} !== {24'd0, 24'h34, 48'd0, 4'b0100, 6'h02, 1'b0}) begin failures++;
      $display("FAIL b2b_second_wb: got res=%h mask=%b dest=%h err=%b", wb_res, wb_m, wb_d, wb_e); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    bus.req_valid_i       = 1'b0;
    bus.req_operand_i     = '0;
    bus.req_op_i          = '0;
    bus.req_mask_i        = '0;
    bus.req_dest_i        = '0;
    bus.sfu_core_result_i = '0;
    bus.sfu_core_valid_i  = 1'b0;
    model_clear();
    exp_op = '0;

    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_timeout();
    test_empty_mask();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sfu_lane_sequencer.md
Name: sfu_lane_sequencer

Overview:
- Serialises one 4-lane (SIMT) special-function request onto the single-lane SFU core, one active lane at a time.
- Collects the per-lane results into a vector buffer and emits one vector writeback per request.
- Sits between the control unit's SFU dispatch path and the sfu_core. It replaces ad-hoc per-lane counting in the dispatcher and adds lane masking and a response watchdog.

Parameters:
LANES, 4, number of lanes per request (indexing logic sized by $clog2(LANES))
DW, 24, lane operand/result width (FP24)
TIMEOUT, 255, max cycles to wait for sfu_core_valid_i per lane; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  vector request valid
req_ready_o  out  1  sequencer can accept a request
req_operand_i  in  LANES*DW  lane operands, lane i at [DW*(i+1)-1:DW*i]
req_op_i  in  3  special op code
req_mask_i  in  LANES  active-lane mask
req_dest_i  in  6  destination {bank, reg[4:0]}
sfu_core_operand_o  out  DW  operand to SFU core
sfu_core_special_op_o  out  3  op to SFU core
sfu_valid_o  out  1  one-cycle issue pulse to SFU core
sfu_core_result_i  in  DW  SFU result
sfu_core_valid_i  in  1  SFU result valid (one cycle)
wb_valid_o  out  1  one-cycle vector writeback pulse
wb_result_o  out  LANES*DW  collected results
wb_mask_o  out  LANES  lanes written (request mask)
wb_dest_o  out  6  latched destination
wb_err_o  out  1  at least one lane timed out
busy_o  out  1  request in flight

Behaviour:
- Reset: state IDLE; req_ready_o=1; sfu_valid_o=0; wb_valid_o=0; wb_err_o=0; busy_o=0; sfu_core_operand_o, sfu_core_special_op_o, wb_result_o, wb_mask_o, wb_dest_o=0; internal pending mask, lane index, timer=0.
- All outputs are registered. req_ready_o = (state==IDLE); busy_o = !req_ready_o.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, on req_valid_i && req_ready_o:
  - Latch operands, op, mask, dest. Set pending=mask. Clear the result buffer and error flag.
  - Go to ISSUE if mask!=0, else DONE.
- ISSUE:
  - Select the lowest set bit of pending as lane L.
  - Next cycle: sfu_valid_o=1 for exactly one cycle, sfu_core_operand_o=operand[L], sfu_core_special_op_o=op.
  - Load timer=0 and go to WAIT.
- WAIT, on sfu_core_valid_i:
  - result[L] <= sfu_core_result_i; clear pending[L].
  - Go to ISSUE if pending!=0, else DONE.
- WAIT watchdog: timer increments each cycle with no response. If TIMEOUT!=0 and timer reaches TIMEOUT-1 without a response:
  - result[L] <= 0; set err; clear pending[L]; advance as if a response had arrived.
  - A late response for that lane arriving in a later ISSUE cycle is ignored.
- DONE: wb_valid_o=1 for one cycle with wb_result_o, wb_mask_o, wb_dest_o, wb_err_o. Return to IDLE.
- Inactive lanes read back 0 in wb_result_o.
- sfu_core_valid_i is ignored in IDLE, ISSUE and DONE.
- Response and timeout in the same cycle: the response wins, err is not set.
- Latency, request accepted in cycle 0:
  - First sfu_valid_o in cycle 1.
  - A response in cycle k yields the next issue in cycle k+1.
  - Last response in cycle m gives wb_valid_o in cycle m+1 and req_ready_o=1 in cycle m+2.
  - mask=0 gives wb_valid_o in cycle 1.
- At most one SFU operation is outstanding at any time; no new request is accepted until the writeback completes.
- Reset mid-operation: abort immediately to reset values, no writeback. A stale SFU response after reset is ignored because the block is in IDLE.
- wb_* data outputs hold their values after the pulse until the next DONE.

Test Plan:
- Full mask: mask=4'hF, operands 1,2,3,4, op=3'b010, SFU model returns operand+1 after 2 cycles -> sfu_valid_o pulses lanes 0..3 in order, each for exactly one cycle. Then one wb_valid_o with result {5,4,3,2}, mask F, err 0; total 13 cycles accept-to-wb.
- Sparse mask: mask=4'b1010 -> exactly 2 issues (lanes 1 then 3); wb_result lanes 0 and 2 = 0; wb_mask=4'b1010.
- Empty mask: mask=0 -> no sfu_valid_o; wb_valid_o the cycle after accept; req_ready_o high the next cycle.
- Timeout: TIMEOUT=8, model drops lane 2's response -> lane 2 result 0, wb_err_o=1, lane 3 still issued.
  - Lane 2's late response injected during lane 3's ISSUE cycle -> ignored.
- Reset in WAIT of lane 1 -> all outputs at reset values the next cycle, no wb_valid_o.
  - Stale sfu_core_valid_i after reset -> no state change.
  - A new request then completes normally.
- Back-to-back: req_valid_i held high with two queued requests -> second accepted only in the cycle req_ready_o returns high; no overlap of SFU issues.
